// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux, with a hold timer
// that forces rotation when a holder keeps the mux while others are waiting.
module mux_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy
);

    localparam int unsigned N_REQ     = 8;
    localparam logic [7:0]  HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_cnt;
    logic [2:0] r_owner;
    logic [7:0] r_grant;
    logic [2:0] r_sel;
    logic       r_busy;

    logic [7:0] w_others;
    logic [2:0] w_owner_next;
    logic [2:0] w_pick_ptr;
    logic [2:0] w_pick_owner;
    logic       w_owner_req;
    logic       w_any_other;
    logic       w_hold_done;

    // First set bit of v scanning start, start+1, ... modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] v, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + 3'(i);
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // The owner is masked out so preempt and release share one search.
    assign w_others     = req & ~(8'b1 << r_owner);
    assign w_owner_next = r_owner + 3'd1;
    assign w_pick_ptr   = rr_pick(req, r_ptr);
    assign w_pick_owner = rr_pick(w_others, w_owner_next);
    assign w_owner_req  = req[r_owner];
    assign w_any_other  = |w_others;
    assign w_hold_done  = (r_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_cnt   <= 8'd0;
            r_owner <= 3'd0;
            r_grant <= 8'h00;
            r_sel   <= 3'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_owner <= w_pick_ptr;
                        r_grant <= 8'b1 << w_pick_ptr;
                        r_sel   <= w_pick_ptr;
                        r_busy  <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req || (w_hold_done && w_any_other)) begin
                        // Release or preempt: rotate past the current owner.
                        r_ptr <= w_owner_next;
                        r_cnt <= 8'd0;
                        if (w_any_other) begin
                            r_owner <= w_pick_owner;
                            r_grant <= 8'b1 << w_pick_owner;
                            r_sel   <= w_pick_owner;
                        end else begin
                            r_grant <= 8'h00;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (!w_hold_done) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign busy  = r_busy;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: directed vectors push expected outputs,
// a monitor pops and compares one entry per clock after the edge.
module tb_mux_arbiter;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] s;
        logic       b;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;

    exp_t  q_exp[$];
    string q_tag[$];
    bit    stim_done;
    int    n_checks;
    int    n_fail;

    mux_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs on the falling edge; expectation applies after the next rising edge.
    task automatic step(input logic rst, input logic [7:0] r, input logic [7:0] g,
                        input logic [2:0] s, input logic b, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        req   = r;
        e.g = g;
        e.s = s;
        e.b = b;
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    initial begin
        logic [2:0] w;
        rst_n     = 1'b0;
        req       = 8'h00;
        stim_done = 1'b0;

        // Reset with all requests asserted, then first grant.
        for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, "reset_hold");
        step(1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, "first_grant");
        step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "first_release");

        // Single request; sel holds while idle.
        step(1'b1, 8'h08, 8'h08, 3'd3, 1'b1, "single_grant");
        step(1'b1, 8'h00, 8'h00, 3'd3, 1'b0, "single_release");

        // Handover with no idle gap.
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "reset_ptr0");
        step(1'b1, 8'h05, 8'h01, 3'd0, 1'b1, "handover_first");
        step(1'b1, 8'h04, 8'h04, 3'd2, 1'b1, "handover_next");
        step(1'b1, 8'h00, 8'h00, 3'd2, 1'b0, "handover_idle");

        // Full contention: each requester holds exactly 4 cycles.
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "reset_rot");
        for (int k = 0; k < 33; k++) begin
            w = 3'((k / 4) % 8);
            step(1'b1, 8'hFF, 8'b1 << w, w, 1'b1, "rotate");
        end
        step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "rotate_idle");

        // No contention: holder keeps grant past counter saturation.
        for (int k = 0; k < 20; k++) step(1'b1, 8'h10, 8'h10, 3'd4, 1'b1, "solo_hold");
        step(1'b1, 8'h00, 8'h00, 3'd4, 1'b0, "solo_release");

        // Pointer wrap 7 -> 0, then reset mid-grant clears the pointer.
        step(1'b1, 8'h40, 8'h40, 3'd6, 1'b1, "grant6");
        step(1'b1, 8'h00, 8'h00, 3'd6, 1'b0, "release6");
        step(1'b1, 8'h81, 8'h80, 3'd7, 1'b1, "wrap_grant7");
        step(1'b0, 8'h81, 8'h00, 3'd0, 1'b0, "reset_midgrant");
        step(1'b1, 8'h81, 8'h01, 3'd0, 1'b1, "post_reset_grant0");
        step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "post_reset_idle");

        // Lower index waits for preempt, then wins by wrapped search.
        step(1'b1, 8'h20, 8'h20, 3'd5, 1'b1, "hold5_c0");
        step(1'b1, 8'h21, 8'h20, 3'd5, 1'b1, "hold5_c1");
        step(1'b1, 8'h21, 8'h20, 3'd5, 1'b1, "hold5_c2");
        step(1'b1, 8'h21, 8'h20, 3'd5, 1'b1, "hold5_c3");
        step(1'b1, 8'h21, 8'h01, 3'd0, 1'b1, "preempt_to0");
        step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "preempt_idle");

        stim_done = 1'b1;
    end

    // Monitor: one expectation per clock, sampled 1 time unit after the edge.
    initial begin
        exp_t  e;
        string tag;
        n_checks = 0;
        n_fail   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() != 0) begin
                e   = q_exp.pop_front();
                tag = q_tag.pop_front();
                n_checks++;
                if (grant !== e.g || sel !== e.s || busy !== e.b) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got grant=%h sel=%0d busy=%b, expected grant=%h sel=%0d busy=%b",
                             tag, $time, grant, sel, busy, e.g, e.s, e.b);
                end
                n_checks++;
                if (busy !== (|grant)) begin
                    n_fail++;
                    $display("FAIL %s @%0t: busy=%b inconsistent with grant=%h", tag, $time, busy, grant);
                end
                n_checks++;
                if (!$onehot0(grant)) begin
                    n_fail++;
                    $display("FAIL %s @%0t: grant=%h is multi-hot", tag, $time, grant);
                end
                n_checks++;
                if (busy === 1'b1 && grant !== (8'b1 << sel)) begin
                    n_fail++;
                    $display("FAIL %s @%0t: sel=%0d does not match grant=%h", tag, $time, sel, grant);
                end
            end else if (stim_done) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
